// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, fetches over a req/ready handshake, and feeds the IF/ID register,
// with a one-entry skid for decode stalls. Optional macro FETCH_STALL_CNT_EN adds a stall-cycle counter.
module instruction_fetch_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   Clk,
    input  logic                   Reset,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   imem_ready,
    input  logic                   stall_id,
    input  logic                   branch_taken,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    output logic                   if_id_valid,
    output logic [INSTR_WIDTH-1:0] if_id_instr,
`ifdef FETCH_STALL_CNT_EN
    output logic [31:0]            fetch_stall_cycles,
`endif
    output logic [ADDR_WIDTH-1:0]  if_id_pc_plus4
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = {{(ADDR_WIDTH-3){1'b0}}, 3'b100};

    state_t                 state_r, state_s;
    logic [ADDR_WIDTH-1:0]  pc_r, pc_s;
    logic [ADDR_WIDTH-1:0]  pend_r, pend_s;
    logic [INSTR_WIDTH-1:0] skid_instr_r, skid_instr_s;
    logic [ADDR_WIDTH-1:0]  skid_pc4_r, skid_pc4_s;
    logic                   valid_r, valid_s;
    logic [INSTR_WIDTH-1:0] instr_r, instr_s;
    logic [ADDR_WIDTH-1:0]  pc4_r, pc4_s;
    logic [ADDR_WIDTH-1:0]  pc_plus4_s;
    logic                   accept_s;

    assign pc_plus4_s     = pc_r + PC_STEP;
    assign accept_s       = !valid_r || !stall_id;
    // HOLD has no request in flight; reset must drop the request at once.
    assign imem_req       = (state_r != HOLD) && !Reset;
    assign imem_addr      = pc_r;
    assign if_id_valid    = valid_r;
    assign if_id_instr    = instr_r;
    assign if_id_pc_plus4 = pc4_r;

    // Next-state, PC, skid and IF/ID update; redirects take priority.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        pend_s       = pend_r;
        skid_instr_s = skid_instr_r;
        skid_pc4_s   = skid_pc4_r;
        valid_s      = valid_r;
        instr_s      = instr_r;
        pc4_s        = pc4_r;
        if (branch_taken) begin
            valid_s = 1'b0;
            case (state_r)
                FETCH: begin
                    if (imem_ready) begin
                        pc_s = branch_target;
                    end else begin
                        pend_s  = branch_target;
                        state_s = DROP;
                    end
                end
                HOLD: begin
                    pc_s    = branch_target;
                    state_s = FETCH;
                end
                DROP: begin
                    pend_s = branch_target;
                end
                default: begin
                    state_s = FETCH;
                end
            endcase
        end else begin
            case (state_r)
                FETCH: begin
                    if (imem_ready) begin
                        pc_s = pc_plus4_s;
                        if (accept_s) begin
                            valid_s = 1'b1;
                            instr_s = imem_rdata;
                            pc4_s   = pc_plus4_s;
                        end else begin
                            skid_instr_s = imem_rdata;
                            skid_pc4_s   = pc_plus4_s;
                            state_s      = HOLD;
                        end
                    end else if (accept_s) begin
                        valid_s = 1'b0;
                    end else begin
                        valid_s = valid_r;
                    end
                end
                HOLD: begin
                    if (accept_s) begin
                        valid_s = 1'b1;
                        instr_s = skid_instr_r;
                        pc4_s   = skid_pc4_r;
                        state_s = FETCH;
                    end else begin
                        state_s = HOLD;
                    end
                end
                DROP: begin
                    if (accept_s) begin
                        valid_s = 1'b0;
                    end else begin
                        valid_s = valid_r;
                    end
                    if (imem_ready) begin
                        pc_s    = pend_r;
                        state_s = FETCH;
                    end else begin
                        state_s = DROP;
                    end
                end
                default: begin
                    state_s = FETCH;
                end
            endcase
        end
    end

    // State, PC and IF/ID registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r      <= FETCH;
            pc_r         <= RESET_PC;
            pend_r       <= '0;
            skid_instr_r <= '0;
            skid_pc4_r   <= '0;
            valid_r      <= 1'b0;
            instr_r      <= '0;
            pc4_r        <= '0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            pend_r       <= pend_s;
            skid_instr_r <= skid_instr_s;
            skid_pc4_r   <= skid_pc4_s;
            valid_r      <= valid_s;
            instr_r      <= instr_s;
            pc4_r        <= pc4_s;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_r;
    logic        stall_cycle_s;

    assign stall_cycle_s      = (imem_req && !imem_ready) || (state_r == HOLD) || (state_r == DROP);
    assign fetch_stall_cycles = stall_cnt_r;

    // Saturating count of cycles in which no useful word arrives.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stall_cnt_r <= 32'd0;
        end else if (stall_cycle_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed test-plan scenarios with literal
// expectations plus randomized traffic checked every cycle against a request/response model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        stall_id;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] fetch_stall_cycles;
`endif

    instruction_fetch_unit #(
        .ADDR_WIDTH(32),
        .INSTR_WIDTH(32),
        .RESET_PC(RPC)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .imem_ready(imem_ready),
        .stall_id(stall_id),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .if_id_valid(if_id_valid),
        .if_id_instr(if_id_instr),
`ifdef FETCH_STALL_CNT_EN
        .fetch_stall_cycles(fetch_stall_cycles),
`endif
        .if_id_pc_plus4(if_id_pc_plus4)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    // Model: next fetch address, whether the in-flight response is stale, a held word, the IF/ID view.
    logic [31:0] m_pc, m_pend, m_held_instr, m_held_pc4, m_instr, m_pc4;
    bit          m_valid, m_held, m_stale;
    bit          cmp_en = 1'b0;
    logic [31:0] last_rd;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] m_cnt;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RPC; m_pend = 32'd0; m_held_instr = 32'd0; m_held_pc4 = 32'd0;
        m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0; m_held = 1'b0; m_stale = 1'b0;
`ifdef FETCH_STALL_CNT_EN
        m_cnt = 32'd0;
`endif
    endtask

    task automatic model_step(input bit st, input bit rdy, input bit br, input logic [31:0] tgt,
                              input logic [31:0] rd);
        bit acc;
        bit req;
        acc = !m_valid || !st;
        req = !m_held;
`ifdef FETCH_STALL_CNT_EN
        if (((req && !rdy) || m_held || m_stale) && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
`endif
        if (br) begin
            m_valid = 1'b0;
            if (m_stale) begin
                m_pend = tgt;
            end else if (m_held) begin
                m_held = 1'b0;
                m_pc = tgt;
            end else if (rdy) begin
                m_pc = tgt;
            end else begin
                m_stale = 1'b1;
                m_pend = tgt;
            end
        end else if (m_held) begin
            if (acc) begin
                m_valid = 1'b1; m_instr = m_held_instr; m_pc4 = m_held_pc4; m_held = 1'b0;
            end
        end else if (m_stale) begin
            if (acc) m_valid = 1'b0;
            if (rdy) begin
                m_pc = m_pend; m_stale = 1'b0;
            end
        end else if (rdy) begin
            if (acc) begin
                m_valid = 1'b1; m_instr = rd; m_pc4 = m_pc + 32'd4;
            end else begin
                m_held = 1'b1; m_held_instr = rd; m_held_pc4 = m_pc + 32'd4;
            end
            m_pc = m_pc + 32'd4;
        end else if (acc) begin
            m_valid = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, advance the model at the clock edge, return at the next falling edge.
    task automatic cycle(input bit st, input bit rdy, input bit br, input logic [31:0] tgt);
        last_rd = $urandom;
        stall_id = st; imem_ready = rdy; branch_taken = br; branch_target = tgt; imem_rdata = last_rd;
        @(posedge Clk);
        model_step(st, rdy, br, tgt, last_rd);
        @(negedge Clk);
    endtask

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge Clk) begin
        if (cmp_en && !Reset) begin
            chk("cmp_req", {31'd0, imem_req}, {31'd0, !m_held});
            if (!m_held) chk("cmp_addr", imem_addr, m_pc);
            chk("cmp_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
            if (m_valid) begin
                chk("cmp_instr", if_id_instr, m_instr);
                chk("cmp_pc4", if_id_pc_plus4, m_pc4);
            end
`ifdef FETCH_STALL_CNT_EN
            chk("cmp_stall_cnt", fetch_stall_cycles, m_cnt);
`endif
        end
    end

    initial begin
        logic [31:0] skid_word;
`ifdef FETCH_STALL_CNT_EN
        logic [31:0] cnt0;
`endif
        bit st, br, rdy;
        logic [31:0] tgt;

        Reset = 1'b1; stall_id = 1'b0; imem_ready = 1'b0; branch_taken = 1'b0;
        branch_target = 32'd0; imem_rdata = 32'd0; last_rd = 32'd0;
        model_reset();
        repeat (2) @(negedge Clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_instr", if_id_instr, 32'd0);
        chk("rst_pc4", if_id_pc_plus4, 32'd0);
        chk("rst_addr", imem_addr, RPC);
`ifdef FETCH_STALL_CNT_EN
        chk("rst_cnt", fetch_stall_cycles, 32'd0);
`endif
        Reset = 1'b0;
        cmp_en = 1'b1;
        #1;
        chk("first_addr", imem_addr, 32'h0040_0000);
        chk("first_req", {31'd0, imem_req}, 32'd1);

        // Zero-wait streaming
        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        chk("seq1_addr", imem_addr, 32'h0040_0004);
        chk("seq1_valid", {31'd0, if_id_valid}, 32'd1);
        chk("seq1_pc4", if_id_pc_plus4, 32'h0040_0004);
        chk("seq1_instr", if_id_instr, last_rd);
        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        chk("seq2_addr", imem_addr, 32'h0040_0008);
        chk("seq2_pc4", if_id_pc_plus4, 32'h0040_0008);

        // Decode stall for three cycles: next word parks in the skid
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        skid_word = last_rd;
        chk("stall1_req", {31'd0, imem_req}, 32'd0);
        chk("stall1_pc4", if_id_pc_plus4, 32'h0040_0008);
        cycle(1'b1, 1'b0, 1'b0, 32'd0);
        chk("stall2_req", {31'd0, imem_req}, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 32'd0);
        chk("stall3_req", {31'd0, imem_req}, 32'd0);
        chk("stall3_valid", {31'd0, if_id_valid}, 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        chk("skid_pc4", if_id_pc_plus4, 32'h0040_000C);
        chk("skid_instr", if_id_instr, skid_word);
        chk("skid_addr", imem_addr, 32'h0040_000C);

        // Redirect while a request waits
        cycle(1'b0, 1'b0, 1'b1, 32'h0040_0100);
        chk("drop_addr", imem_addr, 32'h0040_000C);
        chk("drop_valid", {31'd0, if_id_valid}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        chk("drop_addr2", imem_addr, 32'h0040_000C);
        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        chk("drop_done_addr", imem_addr, 32'h0040_0100);
        chk("drop_done_valid", {31'd0, if_id_valid}, 32'd0);

        // Redirect coinciding with ready
        cycle(1'b0, 1'b1, 1'b1, 32'h0040_0200);
        chk("brrdy_valid", {31'd0, if_id_valid}, 32'd0);
        chk("brrdy_addr", imem_addr, 32'h0040_0200);

        // Redirect while stalled with a full skid
        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        chk("pre_valid", {31'd0, if_id_valid}, 32'd1);
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        chk("full_req", {31'd0, imem_req}, 32'd0);
        cycle(1'b1, 1'b0, 1'b1, 32'h0040_0300);
        chk("brskid_valid", {31'd0, if_id_valid}, 32'd0);
        chk("brskid_addr", imem_addr, 32'h0040_0300);
        chk("brskid_req", {31'd0, imem_req}, 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        chk("brskid_pc4", if_id_pc_plus4, 32'h0040_0304);

        // PC wrap
        cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        chk("wrap_pc4", if_id_pc_plus4, 32'h0000_0000);

`ifdef FETCH_STALL_CNT_EN
        cnt0 = fetch_stall_cycles;
`endif
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 32'd0);
`ifdef FETCH_STALL_CNT_EN
        chk("stall_cnt_delta", fetch_stall_cycles - cnt0, 32'd4);
`endif
        cycle(1'b0, 1'b1, 1'b0, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            st  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 9) == 0);
            rdy = !m_held && ($urandom_range(0, 2) != 0);
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : $urandom;
            cycle(st, rdy, br, tgt);
        end

        // Reset in the middle of an outstanding request
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        cmp_en = 1'b0;
        Reset = 1'b1;
        #1;
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        chk("midrst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("midrst_addr", imem_addr, RPC);
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        cmp_en = 1'b1;
        repeat (20) cycle(1'b0, 1'b1, 1'b0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
